// File: rtl/uart_beacon_seq.sv
// Ring-buffers the last DEPTH received bytes and periodically (or on trigger) replays them
// through uart_tx as a framed burst: HEADER, buffered bytes oldest-first, TRAILER.
module uart_beacon_seq #(
    parameter int          PERIOD_CYCLES = 200_000_000,
    parameter int          DEPTH         = 4,
    parameter logic [7:0]  RESET_BYTE    = 8'hAA,
    parameter logic [7:0]  HEADER        = 8'h55,
    parameter logic [7:0]  TRAILER       = 8'h0A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    input  logic       trigger,
    output logic [7:0] tx_data,
    output logic       tx_send,
    output logic       frame_active,
    output logic [7:0] rx_count
);

    localparam int CW  = $clog2(PERIOD_CYCLES);
    localparam int WPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW  = $clog2(DEPTH + 2);

    localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD_CYCLES - 1);
    localparam logic [WPW-1:0] WP_LAST  = WPW'(DEPTH - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SEND  = 3'd2,
        S_GAP   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           tick;
    logic           req;
    logic           pending_q;
    logic           start_frame;
    logic           send_fire;
    logic           drain_done;
    logic           last_byte;
    logic [WPW-1:0] wp_q;
    logic [7:0]     ring_q [DEPTH];
    logic [7:0]     snap_q [DEPTH];
    logic [7:0]     snap_d [DEPTH];
    logic [IW-1:0]  idx_q;
    logic [7:0]     byte_sel;

    // Free-running period counter; tick marks the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == CNT_LAST);
    assign req  = tick | trigger;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q     <= '0;
            rx_count <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= RESET_BYTE;
            end
        end else if (rx_valid) begin
            ring_q[wp_q] <= rx_data;
            wp_q         <= (wp_q == WP_LAST) ? '0 : wp_q + WPW'(1);
            rx_count     <= (rx_count == 8'hFF) ? 8'hFF : rx_count + 8'd1;
        end
    end

    function automatic logic [WPW-1:0] ring_idx(input logic [WPW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= DEPTH) begin
            sum = sum - DEPTH;
        end
        return WPW'(sum);
    endfunction

    // buf[wp] is the oldest entry, so the snapshot is the ring rotated to start there.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            snap_d[i] = ring_q[ring_idx(wp_q, i)];
        end
    end

    assign last_byte = (idx_q == IDX_LAST);

    always_comb begin
        byte_sel = TRAILER;
        if (idx_q == '0) begin
            byte_sel = HEADER;
        end else if (!last_byte) begin
            byte_sel = snap_q[idx_q - IW'(1)];
        end
    end

    // tx_send/tx_busy: tx_send is a registered one-cycle strobe, raised only after
    // tx_busy was sampled low in SEND; the byte is handed off on that strobe and the
    // next byte waits in DRAIN until uart_tx drops tx_busy again.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        send_fire   = 1'b0;
        drain_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req || pending_q) begin
                    state_d     = S_LOAD;
                    start_frame = 1'b1;
                end
            end
            S_LOAD: state_d = S_SEND;
            S_SEND: begin
                if (!tx_busy) begin
                    state_d   = S_GAP;
                    send_fire = 1'b1;
                end
            end
            S_GAP: state_d = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    drain_done = 1'b1;
                    state_d    = last_byte ? S_IDLE : S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A single pending slot: requests while busy collapse into one follow-up frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= 1'b0;
            idx_q        <= '0;
            frame_active <= 1'b0;
            tx_data      <= 8'd0;
            tx_send      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= RESET_BYTE;
            end
        end else begin
            tx_send <= send_fire;
            if (state_q == S_IDLE) begin
                pending_q <= 1'b0;
            end else if (req) begin
                pending_q <= 1'b1;
            end
            if (start_frame) begin
                for (int i = 0; i < DEPTH; i++) begin
                    snap_q[i] <= snap_d[i];
                end
                idx_q        <= '0;
                frame_active <= 1'b1;
            end
            if (state_q == S_LOAD) begin
                tx_data <= byte_sel;
            end
            if (drain_done) begin
                if (last_byte) begin
                    frame_active <= 1'b0;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_beacon_seq.sv
// Bench for uart_beacon_seq: three instances (triggered DEPTH=4, periodic DEPTH=4, DEPTH=3)
// sharing the RX stream, each with an ideal uart_tx model that stays busy 10 cycles per byte.
module tb_uart_beacon_seq;

    localparam logic [7:0] HDR  = 8'h55;
    localparam logic [7:0] TRL  = 8'h0A;
    localparam logic [7:0] FILL = 8'hAA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       trig      [3];
    logic       tx_busy_w [3];
    logic       tx_send_w [3];
    logic       fa        [3];
    logic [7:0] tx_data_w [3];
    logic [7:0] rx_count_w[3];
    int         busy_cnt  [3];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc;
    int overlap_err = 0;
    logic fa_prev_b = 1'b0;

    logic [7:0] hist[$];
    int         rx_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap0[$];
    logic [7:0] cap1[$];
    logic [7:0] cap2[$];
    int         start_q_b[$];
    int         end_q_b[$];

    typedef struct packed {
        logic [3:0]  n_rx;
        logic [7:0]  first;
        logic [47:0] exp_frame;
        logic [7:0]  exp_count;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    uart_beacon_seq #(.DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy_w[0]), .trigger(trig[0]), .tx_data(tx_data_w[0]),
        .tx_send(tx_send_w[0]), .frame_active(fa[0]), .rx_count(rx_count_w[0])
    );

    uart_beacon_seq #(.PERIOD_CYCLES(1000), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy_w[1]), .trigger(trig[1]), .tx_data(tx_data_w[1]),
        .tx_send(tx_send_w[1]), .frame_active(fa[1]), .rx_count(rx_count_w[1])
    );

    uart_beacon_seq #(.DEPTH(3)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_busy(tx_busy_w[2]), .trigger(trig[2]), .tx_data(tx_data_w[2]),
        .tx_send(tx_send_w[2]), .frame_active(fa[2]), .rx_count(rx_count_w[2])
    );

    // Ideal uart_tx: busy for 10 cycles starting the cycle after it samples tx_send.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) busy_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (tx_send_w[i]) busy_cnt[i] <= 10;
                else if (busy_cnt[i] > 0) busy_cnt[i] <= busy_cnt[i] - 1;
            end
        end
    end

    assign tx_busy_w[0] = (busy_cnt[0] != 0);
    assign tx_busy_w[1] = (busy_cnt[1] != 0);
    assign tx_busy_w[2] = (busy_cnt[2] != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (tx_send_w[0]) cap0.push_back(tx_data_w[0]);
        if (tx_send_w[1]) cap1.push_back(tx_data_w[1]);
        if (tx_send_w[2]) cap2.push_back(tx_data_w[2]);
        for (int i = 0; i < 3; i++) begin
            if (tx_send_w[i] && tx_busy_w[i]) overlap_err++;
        end
        if (rst_n) begin
            if (fa[1] && !fa_prev_b) start_q_b.push_back(cyc);
            if (!fa[1] && fa_prev_b) end_q_b.push_back(cyc);
        end
        fa_prev_b = fa[1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cap_size(input int i);
        case (i)
            0:       return cap0.size();
            1:       return cap1.size();
            default: return cap2.size();
        endcase
    endfunction

    function automatic logic [7:0] cap_pop(input int i);
        logic [7:0] r;
        case (i)
            0:       r = cap0.pop_front();
            1:       r = cap1.pop_front();
            default: r = cap2.pop_front();
        endcase
        return r;
    endfunction

    // Reference frame: header, the newest `depth` received bytes oldest-first
    // (fill value where fewer have arrived since reset), trailer.
    task automatic build_exp(input int depth);
        int idx;
        exp_q.push_back(HDR);
        for (int k = 0; k < depth; k++) begin
            idx = hist.size() - depth + k;
            exp_q.push_back((idx >= 0) ? hist[idx] : FILL);
        end
        exp_q.push_back(TRL);
    endtask

    task automatic check_frame(input int i, input string name);
        logic [7:0] e;
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (cap_size(i) == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL %s[%0d]: got no byte expected %0h", name, k, e);
            end else begin
                check($sformatf("%s[%0d]", name, k), cap_pop(i), e);
            end
            k++;
        end
        check({name, "_extra_bytes"}, cap_size(i), 0);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        hist.push_back(b);
        rx_total++;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_trig(input int i);
        @(negedge clk);
        trig[i] = 1'b1;
        @(negedge clk);
        trig[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string name);
        int n;
        n = 0;
        while (fa[i] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_frame_done"}, fa[i], 1'b0);
    endtask

    function automatic int sat_count();
        return (rx_total > 255) ? 255 : rx_total;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        vecs[0] = '{n_rx: 4'd0, first: 8'h00, exp_frame: 48'h55_AA_AA_AA_AA_0A, exp_count: 8'd0};
        vecs[1] = '{n_rx: 4'd6, first: 8'h01, exp_frame: 48'h55_03_04_05_06_0A, exp_count: 8'd6};
        vecs[2] = '{n_rx: 4'd2, first: 8'h20, exp_frame: 48'h55_05_06_20_21_0A, exp_count: 8'd8};
        vecs[3] = '{n_rx: 4'd1, first: 8'h80, exp_frame: 48'h55_06_20_21_80_0A, exp_count: 8'd9};
        vecs[4] = '{n_rx: 4'd3, first: 8'hFD, exp_frame: 48'h55_80_FD_FE_FF_0A, exp_count: 8'd12};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) trig[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_tx_data%0d", i), tx_data_w[i], 8'h00);
            check($sformatf("rst_tx_send%0d", i), tx_send_w[i], 1'b0);
            check($sformatf("rst_frame_active%0d", i), fa[i], 1'b0);
            check($sformatf("rst_rx_count%0d", i), rx_count_w[i], 8'h00);
        end
        rst_n = 1'b1;

        // Table vectors on the triggered DEPTH=4 instance.
        for (int v = 0; v < 5; v++) begin
            for (int j = 0; j < int'(vecs[v].n_rx); j++) send_rx(vecs[v].first + 8'(j));
            if (v == 0) begin
                @(negedge clk);
                trig[0] = 1'b1;
                @(negedge clk);
                trig[0] = 1'b0;
                lat = 1;
                check("start_frame_active", fa[0], 1'b1);
                while (!tx_send_w[0] && lat < 20) begin
                    @(negedge clk);
                    lat++;
                end
                check("trigger_latency", lat, 3);
            end else begin
                pulse_trig(0);
            end
            wait_idle(0, $sformatf("vec%0d", v));
            for (int k = 0; k < 6; k++) exp_q.push_back(vecs[v].exp_frame[47 - 8*k -: 8]);
            check_frame(0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_rx_count", v), rx_count_w[0], vecs[v].exp_count);
        end

        // Periodic instance: frames start at cycles 1000, 2000, 3000.
        while (cyc < 3100) @(negedge clk);
        check("period_frame_count", start_q_b.size(), 3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("period_start%0d", k),
                  (k < start_q_b.size()) ? start_q_b[k] : -1, 1000 * (k + 1));
        end

        // Trigger, then two more triggers and a tick mid-frame: exactly one extra frame.
        start_q_b.delete();
        end_q_b.delete();
        cap1.delete();
        while (cyc < 3950) @(negedge clk);
        trig[1] = 1'b1;
        build_exp(4);
        @(negedge clk);
        trig[1] = 1'b0;
        while (cyc < 3960) @(negedge clk);
        trig[1] = 1'b1;
        @(negedge clk);
        trig[1] = 1'b0;
        while (cyc < 3970) @(negedge clk);
        trig[1] = 1'b1;
        @(negedge clk);
        trig[1] = 1'b0;
        while (cyc < 3980) @(negedge clk);
        rx_data  = 8'h7F;
        rx_valid = 1'b1;
        hist.push_back(8'h7F);
        rx_total++;
        @(negedge clk);
        rx_valid = 1'b0;
        while (cyc < 4300) @(negedge clk);
        build_exp(4);
        check_frame(1, "pending");
        check("pending_frame_count", start_q_b.size(), 2);
        check("pending_first_start", (start_q_b.size() > 0) ? start_q_b[0] : -1, 3951);
        check("pending_end_count", end_q_b.size(), 2);
        check("pending_back_to_back",
              (start_q_b.size() > 1) ? start_q_b[1] : -1,
              (end_q_b.size() > 0) ? end_q_b[0] + 1 : -2);

        // Saturation of rx_count, then DEPTH=3 ring wrap.
        for (int j = 0; j < 300; j++) send_rx(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) check($sformatf("sat_rx_count%0d", i), rx_count_w[i], 8'd255);
        for (int j = 0; j < 8; j++) send_rx(8'h10 + 8'(j));
        pulse_trig(2);
        wait_idle(2, "wrap");
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h16);
        exp_q.push_back(8'h17);
        exp_q.push_back(8'h0A);
        check_frame(2, "wrap");

        // Randomized frames against the reference model, including RX on the start edge.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) send_rx(8'($urandom_range(0, 255)));
            @(negedge clk);
            trig[0] = 1'b1;
            build_exp(4);
            if ($urandom_range(0, 1) == 1) begin
                rx_data  = 8'($urandom_range(0, 255));
                rx_valid = 1'b1;
                hist.push_back(rx_data);
                rx_total++;
            end
            @(negedge clk);
            trig[0]  = 1'b0;
            rx_valid = 1'b0;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 10)) @(negedge clk);
                send_rx(8'($urandom_range(0, 255)));
            end
            wait_idle(0, $sformatf("rand%0d", it));
            check_frame(0, $sformatf("rand%0d", it));
            check($sformatf("rand%0d_rx_count", it), rx_count_w[0], sat_count());
        end

        // Reset during the third byte of a frame.
        pulse_trig(0);
        n = 0;
        while (cap0.size() < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_third_byte_seen", cap0.size(), 3);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        hist.delete();
        rx_total = 0;
        #1;
        check("abort_tx_data", tx_data_w[0], 8'h00);
        check("abort_tx_send", tx_send_w[0], 1'b0);
        check("abort_frame_active", fa[0], 1'b0);
        check("abort_rx_count", rx_count_w[0], 8'h00);
        cap0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("abort_no_send", cap0.size(), 0);
        check("abort_stays_idle", fa[0], 1'b0);
        pulse_trig(0);
        build_exp(4);
        wait_idle(0, "post_reset");
        check_frame(0, "post_reset");

        check("send_while_busy", overlap_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
